// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state type, output constants and saturating 8-bit helpers
package adc_pkg;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        ACCUM     = 1'b1
    } state_t;

    localparam int         OUT_W     = 8;
    localparam logic [7:0] MIN_RESET = 8'hFF;
    localparam logic [7:0] MAX_RESET = 8'h00;

    function automatic logic [7:0] sat_sub8(input logic [7:0] v, input logic [8:0] s);
        logic [8:0] d;
        d = {1'b0, v} - s;
        return d[8] ? 8'h00 : d[7:0];
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [8:0] s);
        logic [8:0] t;
        t = {1'b0, v} + s;
        return t[8] ? 8'hFF : t[7:0];
    endfunction

endpackage

// File: rtl/adc_edge_detect.sv
// rtl/adc_edge_detect.sv - frame_sync delay register and rising-edge pulse
module adc_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_sync_i,
    output logic sync_edge_o
);

    logic sync_q;
    logic sync_d;

    assign sync_d = frame_sync_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_edge_o = frame_sync_i & ~sync_q;

endmodule

// File: rtl/adc_peak_tracker.sv
// rtl/adc_peak_tracker.sv - per-frame ADC max/min/count tracker; ADC_PEAK_DECAY_EN enables peak-hold decay
module adc_peak_tracker
    import adc_pkg::*;
#(
    parameter int ADC_W      = 12,
    parameter int CNT_W      = 16,
    parameter int DECAY_STEP = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    input  logic             frame_sync,
    output logic [OUT_W-1:0] max_val,
    output logic [OUT_W-1:0] min_val,
    output logic [CNT_W-1:0] sample_count,
    output logic             stats_valid,
    output logic             no_signal,
    output logic             clipped
);

`ifdef ADC_PEAK_DECAY_EN
    localparam bit DECAY_EN = 1'b1;
`else
    localparam bit DECAY_EN = 1'b0;
`endif

    localparam logic [8:0] STEP9 = (DECAY_STEP > 255) ? 9'd255 : 9'(DECAY_STEP);

    logic sync_edge;

    adc_edge_detect u_edge (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_sync_i (frame_sync),
        .sync_edge_o  (sync_edge)
    );

    state_t             state_q, state_d;
    logic [ADC_W-1:0]   acc_max_q, acc_max_d;
    logic [ADC_W-1:0]   acc_min_q, acc_min_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               acc_clip_q, acc_clip_d;
    logic [OUT_W-1:0]   max_val_q, max_val_d;
    logic [OUT_W-1:0]   min_val_q, min_val_d;
    logic [CNT_W-1:0]   sample_count_q, sample_count_d;
    logic               stats_valid_q, stats_valid_d;
    logic               no_signal_q, no_signal_d;
    logic               clipped_q, clipped_d;

    logic [OUT_W-1:0]   frame_max8, frame_min8;
    logic [OUT_W-1:0]   dec_max, dec_min;
    logic [OUT_W-1:0]   pub_max, pub_min;
    logic               sample_clip;

    assign frame_max8  = acc_max_q[ADC_W-1 -: OUT_W];
    assign frame_min8  = acc_min_q[ADC_W-1 -: OUT_W];
    assign dec_max     = sat_sub8(max_val_q, STEP9);
    assign dec_min     = sat_add8(min_val_q, STEP9);
    assign sample_clip = (adc_data == '0) || (adc_data == '1);

    // An empty frame holds (or decays) the previous peaks instead of publishing the reset seeds.
    always_comb begin
        pub_max = frame_max8;
        pub_min = frame_min8;
        if (acc_cnt_q == '0) begin
            pub_max = DECAY_EN ? dec_max : max_val_q;
            pub_min = DECAY_EN ? dec_min : min_val_q;
        end else begin
            if (DECAY_EN && (dec_max > frame_max8)) pub_max = dec_max;
            if (DECAY_EN && (dec_min < frame_min8)) pub_min = dec_min;
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_max_d      = acc_max_q;
        acc_min_d      = acc_min_q;
        acc_cnt_d      = acc_cnt_q;
        acc_clip_d     = acc_clip_q;
        max_val_d      = max_val_q;
        min_val_d      = min_val_q;
        sample_count_d = sample_count_q;
        no_signal_d    = no_signal_q;
        clipped_d      = clipped_q;
        stats_valid_d  = 1'b0;

        case (state_q)
            WAIT_SYNC: begin
                if (sync_edge) state_d = ACCUM;
            end
            ACCUM: begin
                if (sync_edge) begin
                    stats_valid_d  = 1'b1;
                    max_val_d      = pub_max;
                    min_val_d      = pub_min;
                    sample_count_d = acc_cnt_q;
                    clipped_d      = acc_clip_q;
                    no_signal_d    = (acc_cnt_q == '0);
                    acc_max_d      = '0;
                    acc_min_d      = '1;
                    acc_cnt_d      = '0;
                    acc_clip_d     = 1'b0;
                end
                // Updating from the freshly cleared accumulators seeds a coincident sample into the new frame.
                if (adc_valid) begin
                    if (adc_data > acc_max_d) acc_max_d = adc_data;
                    if (adc_data < acc_min_d) acc_min_d = adc_data;
                    if (acc_cnt_d != '1) acc_cnt_d = acc_cnt_d + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (sample_clip) acc_clip_d = 1'b1;
                end
            end
            default: state_d = WAIT_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= WAIT_SYNC;
            acc_max_q      <= '0;
            acc_min_q      <= '1;
            acc_cnt_q      <= '0;
            acc_clip_q     <= 1'b0;
            max_val_q      <= MAX_RESET;
            min_val_q      <= MIN_RESET;
            sample_count_q <= '0;
            stats_valid_q  <= 1'b0;
            no_signal_q    <= 1'b1;
            clipped_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_max_q      <= acc_max_d;
            acc_min_q      <= acc_min_d;
            acc_cnt_q      <= acc_cnt_d;
            acc_clip_q     <= acc_clip_d;
            max_val_q      <= max_val_d;
            min_val_q      <= min_val_d;
            sample_count_q <= sample_count_d;
            stats_valid_q  <= stats_valid_d;
            no_signal_q    <= no_signal_d;
            clipped_q      <= clipped_d;
        end
    end

    assign max_val      = max_val_q;
    assign min_val      = min_val_q;
    assign sample_count = sample_count_q;
    assign stats_valid  = stats_valid_q;
    assign no_signal    = no_signal_q;
    assign clipped      = clipped_q;

endmodule

// File: tb/tb_adc_peak_tracker.sv
// tb/tb_adc_peak_tracker.sv - self-checking bench for adc_peak_tracker (directed and randomized)
module tb_adc_peak_tracker;

    localparam int ADC_W   = 12;
    localparam int CNT_W   = 4;
    localparam int TB_STEP = 4;
    localparam int MAXV    = (1 << ADC_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int OBS_W   = 1 + 8 + 8 + CNT_W + 1 + 1;
`ifdef ADC_PEAK_DECAY_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
    logic             adc_valid = 1'b0;
    logic             frame_sync = 1'b0;
    logic [7:0]       max_val, min_val;
    logic [CNT_W-1:0] sample_count;
    logic             stats_valid, no_signal, clipped;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    adc_peak_tracker #(.ADC_W(ADC_W), .CNT_W(CNT_W), .DECAY_STEP(TB_STEP)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .frame_sync   (frame_sync),
        .max_val      (max_val),
        .min_val      (min_val),
        .sample_count (sample_count),
        .stats_valid  (stats_valid),
        .no_signal    (no_signal),
        .clipped      (clipped)
    );

    wire [OBS_W-1:0] obs = {stats_valid, max_val, min_val, sample_count, no_signal, clipped};

    // Reference model: frame samples kept in a queue, statistics computed at publish time.
    bit m_armed, m_prev_s;
    int m_frame[$];
    int e_max, e_min, e_cnt;
    bit e_sv, e_ns, e_clip;

    task automatic model_reset();
        m_armed = 0; m_prev_s = 0; m_frame.delete();
        e_max = 0; e_min = 255; e_cnt = 0; e_sv = 0; e_ns = 1; e_clip = 0;
    endtask

    task automatic model_publish();
        int fmax, fmin, dmax, dmin;
        bit clip;
        dmax = (e_max > TB_STEP) ? e_max - TB_STEP : 0;
        dmin = (e_min + TB_STEP > 255) ? 255 : e_min + TB_STEP;
        if (m_frame.size() == 0) begin
            if (DEC) begin e_max = dmax; e_min = dmin; end
            e_cnt = 0; e_ns = 1; e_clip = 0;
        end else begin
            fmax = 0; fmin = 255; clip = 0;
            foreach (m_frame[i]) begin
                int t;
                t = m_frame[i] >> (ADC_W - 8);
                if (t > fmax) fmax = t;
                if (t < fmin) fmin = t;
                if (m_frame[i] == 0 || m_frame[i] == MAXV) clip = 1;
            end
            if (DEC && dmax > fmax) fmax = dmax;
            if (DEC && dmin < fmin) fmin = dmin;
            e_max = fmax; e_min = fmin;
            e_cnt = (m_frame.size() > CNT_MAX) ? CNT_MAX : m_frame.size();
            e_ns = 0; e_clip = clip;
        end
    endtask

    task automatic cycle(input bit v, input int d, input bit s);
        bit edge_s;
        adc_valid  = v;
        adc_data   = d[ADC_W-1:0];
        frame_sync = s;
        @(posedge clk);
        edge_s   = s && !m_prev_s;
        m_prev_s = s;
        e_sv     = 0;
        if (!m_armed) begin
            if (edge_s) m_armed = 1;
        end else begin
            if (edge_s) begin
                model_publish();
                e_sv = 1;
                m_frame.delete();
            end
            if (v) m_frame.push_back(d & MAXV);
        end
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; adc_valid = 1'b0; frame_sync = 1'b0; adc_data = '0;
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [OBS_W-1:0] exp;
        reset_n = 1'b0;
        @(posedge clk); #1;
        exp = {1'b0, 8'h00, 8'hFF, CNT_W'(0), 1'b1, 1'b0};
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL reset_values: got %h expected %h", obs, exp); end
        apply_reset();
    endtask

    task automatic test_basic();
        logic [OBS_W-1:0] exp;
        apply_reset();
        cycle(0, 0, 1); cycle(0, 0, 0);
        cycle(1, 'h100, 0); cycle(1, 'hA00, 0); cycle(1, 'h050, 0);
        cycle(0, 0, 1);
        exp = {1'b1, 8'hA0, 8'h05, CNT_W'(3), 1'b0, 1'b0};
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL basic_publish: got %h expected %h", obs, exp); end
        cycle(0, 0, 0);
        vectors++;
        if (stats_valid !== 1'b0) begin errors++; $display("FAIL basic_single_pulse: got %b expected 0", stats_valid); end
    endtask

    task automatic test_pre_sync();
        logic [OBS_W-1:0] exp;
        apply_reset();
        cycle(1, 'hFFF, 0); cycle(1, 'h000, 0);
        cycle(1, 'h555, 1);
        vectors++;
        if (stats_valid !== 1'b0) begin errors++; $display("FAIL presync_no_pulse: got %b expected 0", stats_valid); end
        cycle(1, 'h300, 0); cycle(1, 'h400, 0);
        cycle(0, 0, 1);
        exp = {1'b1, 8'h40, 8'h30, CNT_W'(2), 1'b0, 1'b0};
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL presync_first_publish: got %h expected %h", obs, exp); end
    endtask

    task automatic test_empty();
        logic [OBS_W-1:0] exp;
        cycle(0, 0, 0); cycle(0, 0, 0);
        cycle(0, 0, 1);
        exp = {1'b1, DEC ? 8'h3C : 8'h40, DEC ? 8'h34 : 8'h30, CNT_W'(0), 1'b1, 1'b0};
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL empty_frame: got %h expected %h", obs, exp); end
    endtask

    task automatic test_clip();
        logic [OBS_W-1:0] exp;
        cycle(0, 0, 0);
        cycle(1, 'hFFF, 0); cycle(1, 'h123, 0);
        cycle(0, 0, 1);
        exp = {1'b1, 8'hFF, 8'h12, CNT_W'(2), 1'b0, 1'b1};
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL clip_set: got %h expected %h", obs, exp); end
        cycle(0, 0, 0);
        cycle(1, 'h456, 0); cycle(1, 'h789, 0);
        cycle(0, 0, 1);
        exp = {1'b1, DEC ? 8'hFB : 8'h78, DEC ? 8'h16 : 8'h45, CNT_W'(2), 1'b0, 1'b0};
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL clip_clear: got %h expected %h", obs, exp); end
    endtask

    task automatic test_coincident();
        logic [OBS_W-1:0] exp;
        apply_reset();
        cycle(0, 0, 1); cycle(0, 0, 0);
        cycle(1, 'h200, 0);
        cycle(1, 'h7F0, 1);
        exp = {1'b1, 8'h20, 8'h20, CNT_W'(1), 1'b0, 1'b0};
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL coincident_old_frame: got %h expected %h", obs, exp); end
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        exp = {1'b1, 8'h7F, DEC ? 8'h24 : 8'h7F, CNT_W'(1), 1'b0, 1'b0};
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL coincident_new_frame: got %h expected %h", obs, exp); end
    endtask

    task automatic test_saturate();
        logic [OBS_W-1:0] exp;
        apply_reset();
        cycle(0, 0, 1); cycle(0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 'h800, 0);
        cycle(0, 0, 1);
        exp = {1'b1, 8'h80, 8'h80, CNT_W'(CNT_MAX), 1'b0, 1'b0};
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL count_saturate: got %h expected %h", obs, exp); end
    endtask

`ifdef ADC_PEAK_DECAY_EN
    task automatic test_decay();
        apply_reset();
        cycle(0, 0, 1); cycle(0, 0, 0);
        cycle(1, 'hC00, 0);
        cycle(0, 0, 1);
        vectors++;
        if ({max_val, min_val} !== 16'hC0C0) begin errors++; $display("FAIL decay_first: got %h expected c0c0", {max_val, min_val}); end
        cycle(0, 0, 0);
        cycle(1, 'h200, 0);
        cycle(0, 0, 1);
        vectors++;
        if ({max_val, min_val} !== 16'hBC20) begin errors++; $display("FAIL decay_second: got %h expected bc20", {max_val, min_val}); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [OBS_W-1:0] exp;
        apply_reset();
        cycle(0, 0, 1); cycle(0, 0, 0);
        cycle(1, 'h900, 0); cycle(1, 'h300, 0);
        cycle(0, 0, 1);
        cycle(1, 'hA00, 0);
        #2;
        reset_n = 1'b0;
        #1;
        exp = {1'b0, 8'h00, 8'hFF, CNT_W'(0), 1'b1, 1'b0};
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL async_reset_immediate: got %h expected %h", obs, exp); end
        adc_valid = 1'b0;
        @(posedge clk); #1;
        model_reset();
        reset_n = 1'b1;
        cycle(1, 'h100, 0);
        cycle(0, 0, 1);
        vectors++;
        if (stats_valid !== 1'b0) begin errors++; $display("FAIL reset_first_edge_no_pulse: got %b expected 0", stats_valid); end
        cycle(1, 'h600, 0);
        cycle(0, 0, 1);
        exp = {1'b1, 8'h60, 8'h60, CNT_W'(1), 1'b0, 1'b0};
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL reset_second_edge_publish: got %h expected %h", obs, exp); end
    endtask

    task automatic test_random();
        logic [OBS_W-1:0] exp;
        bit v, s;
        int d, r;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            s = ($urandom_range(0, 7) == 0);
            v = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 15);
            d = (r == 0) ? 0 : (r == 1) ? MAXV : int'($urandom_range(0, MAXV));
            cycle(v, d, s);
            exp = {e_sv, e_max[7:0], e_min[7:0], e_cnt[CNT_W-1:0], e_ns, e_clip};
            vectors++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %h expected %h", n, obs, exp);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_pre_sync();
        test_empty();
        test_clip();
        test_coincident();
        test_saturate();
`ifdef ADC_PEAK_DECAY_EN
        test_decay();
`endif
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
